// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stopwatch_ctrl: button sync/debounce, run/pause/clear FSM, tick prescaler |
// | Optional lap freeze built when STOPWATCH_LAP_EN is defined.              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       run,
  output logic       tick,
  output logic       clr,
  output logic       hold,
  output logic [1:0] state
);

  localparam int c_DB_W = $clog2(DB_CYCLES);
  localparam int c_PS_W = $clog2(TICK_DIV);
  localparam logic [c_DB_W-1:0] c_DB_MAX   = c_DB_W'(DB_CYCLES - 1);
  localparam logic [c_PS_W-1:0] c_TICK_MAX = c_PS_W'(TICK_DIV - 1);
`ifdef STOPWATCH_LAP_EN
  localparam int c_NBTN = 3;
`else
  localparam int c_NBTN = 2;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_LAP     = 2'd3
  } state_t;

  logic [c_NBTN-1:0] w_raw;
  logic [c_NBTN-1:0] w_press;
  logic              w_start;
  logic              w_clear;
  logic              w_lap;

`ifdef STOPWATCH_LAP_EN
  assign w_raw = {btn_lap, btn_clear, btn_start_stop};
  assign w_lap = w_press[2];
`else
  logic w_unused_lap;
  assign w_raw        = {btn_clear, btn_start_stop};
  assign w_lap        = 1'b0;
  assign w_unused_lap = btn_lap;
`endif
  assign w_start = w_press[0];
  assign w_clear = w_press[1];

  for (genvar i = 0; i < c_NBTN; i++) begin : g_btn
    logic [1:0]        r_sync;
    logic [c_DB_W-1:0] r_cnt;
    logic              r_level;
    logic              r_press;

    // Level flips on the DB_CYCLES-th differing sample; the press fires on that same edge.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync  <= 2'b00;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_press <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], w_raw[i]};
        r_press <= 1'b0;
        if (r_sync[1] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_MAX) begin
          r_cnt   <= '0;
          r_level <= r_sync[1];
          r_press <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[i] = r_press;
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_clr_nxt;
  logic              w_run_nxt;
  logic              w_hold_nxt;
  logic              w_adv;
  logic              r_run;
  logic              r_tick;
  logic              r_clr;
  logic              r_hold;
  logic [c_PS_W-1:0] r_presc;

  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_clear)      w_clr_nxt   = 1'b1;
        else if (w_start) w_state_nxt = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (w_start)      w_state_nxt = ST_PAUSED;
        else if (w_lap)   w_state_nxt = ST_LAP;
      end
      ST_PAUSED: begin
        if (w_clear) begin
          w_state_nxt = ST_IDLE;
          w_clr_nxt   = 1'b1;
        end else if (w_start) begin
          w_state_nxt = ST_RUNNING;
        end
      end
      ST_LAP: begin
        if (w_start)      w_state_nxt = ST_PAUSED;
        else if (w_lap)   w_state_nxt = ST_RUNNING;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_run_nxt = (w_state_nxt == ST_RUNNING) || (w_state_nxt == ST_LAP);
`ifdef STOPWATCH_LAP_EN
    w_hold_nxt = (w_state_nxt == ST_LAP);
`else
    w_hold_nxt = 1'b0;
`endif
  end

  // Prescaler only advances across edges where run stays high, so a stop edge cannot emit a tick.
  assign w_adv = r_run && w_run_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_run   <= 1'b0;
      r_tick  <= 1'b0;
      r_clr   <= 1'b0;
      r_hold  <= 1'b0;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_clr   <= w_clr_nxt;
      r_hold  <= w_hold_nxt;
      r_tick  <= w_adv && (r_presc == c_TICK_MAX);
      if (w_clr_nxt) begin
        r_presc <= '0;
      end else if (w_adv) begin
        r_presc <= (r_presc == c_TICK_MAX) ? '0 : r_presc + 1'b1;
      end
    end
  end

  assign run   = r_run;
  assign tick  = r_tick;
  assign clr   = r_clr;
  assign hold  = r_hold;
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stopwatch_ctrl: directed + randomized bench for stopwatch_ctrl        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_stopwatch_ctrl;

  localparam int TD = 10;
  localparam int DB = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       b_ss, b_clr, b_lap;
  logic       run, tick, clr, hold;
  logic [1:0] state;

  stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .btn_start_stop (b_ss),
    .btn_clear      (b_clr),
    .btn_lap        (b_lap),
    .run            (run),
    .tick           (tick),
    .clr            (clr),
    .hold           (hold),
    .state          (state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int clr_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw-sample history per button, window test for debounce,
  // transition table for the FSM, and elapsed run-time for ticks.
  bit [15:0] m_hist[3];
  bit        m_level[3];
  bit        m_pp[3];
  int        m_state;
  bit        m_run, m_tick, m_clr, m_hold;
  int        m_elapsed;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = '0; m_level[i] = 1'b0; m_pp[i] = 1'b0;
    end
    m_state = 0; m_run = 0; m_tick = 0; m_clr = 0; m_hold = 0; m_elapsed = 0;
  endtask

  task automatic model_step();
    bit raw[3];
    bit pn[3];
    bit [15:0] win;
    bit [15:0] mask;
    int ns;
    bit nclr;
    bit prev_run;
    raw  = '{b_ss, b_clr, b_lap};
    mask = 16'((1 << DB) - 1);
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = {m_hist[i][14:0], raw[i]};
      win = (m_hist[i] >> 2) & mask;
      pn[i] = 1'b0;
      if (!m_level[i] && win == mask) begin
        m_level[i] = 1'b1;
        pn[i] = 1'b1;
      end else if (m_level[i] && win == 16'd0) begin
        m_level[i] = 1'b0;
      end
    end
    if (!LAP_EN) pn[2] = 1'b0;
    ns = m_state; nclr = 1'b0;
    case (m_state)
      0: if (m_pp[1]) nclr = 1'b1; else if (m_pp[0]) ns = 1;
      1: if (m_pp[0]) ns = 2; else if (m_pp[2]) ns = 3;
      2: if (m_pp[1]) begin ns = 0; nclr = 1'b1; end else if (m_pp[0]) ns = 1;
      default: if (m_pp[0]) ns = 2; else if (m_pp[2]) ns = 1;
    endcase
    prev_run = m_run;
    m_run  = (ns == 1) || (ns == 3);
    m_tick = 1'b0;
    if (nclr) m_elapsed = 0;
    else if (prev_run && m_run) begin
      m_elapsed++;
      m_tick = (m_elapsed % TD) == 0;
    end
    m_clr   = nclr;
    m_hold  = (ns == 3);
    m_state = ns;
    m_pp    = pn;
  endtask

  // One clock: sample after the edge, advance model, compare, return at negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (!reset_n) model_reset();
    else          model_step();
    chk("state", 32'(state), 32'(m_state));
    chk("run",   32'(run),   32'(m_run));
    chk("tick",  32'(tick),  32'(m_tick));
    chk("clr",   32'(clr),   32'(m_clr));
    chk("hold",  32'(hold),  32'(m_hold));
    chk("tick_without_run", 32'(tick & ~run), 32'd0);
    chk("tick_with_clr",    32'(tick & clr),  32'd0);
    if (clr) clr_seen++;
    @(negedge clk);
  endtask

  task automatic press(input bit s, input bit c, input bit l, input int n);
    b_ss = s; b_clr = c; b_lap = l;
    repeat (n) cyc();
    b_ss = 1'b0; b_clr = 1'b0; b_lap = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    int first_run;
    int changes;
    logic [1:0] prev_state;
    reset_n = 1'b0; b_ss = 1'b0; b_clr = 1'b0; b_lap = 1'b0;
    model_reset();
    @(negedge clk);
    idle(3);
    reset_n = 1'b1;

    // Held start press: run rises on edge 7, exactly one state change.
    b_ss = 1'b1; first_run = 0; changes = 0; prev_state = state;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (run && first_run == 0) first_run = k;
      if (state != prev_state) changes++;
      prev_state = state;
    end
    b_ss = 1'b0;
    chk("run_latency", 32'(first_run), 32'd7);
    chk("held_press_changes", 32'(changes), 32'd1);
    idle(25);

    // Pause, stay paused, resume.
    press(1, 0, 0, 6); idle(20);
    chk("paused", 32'(state), 32'd2);
    press(1, 0, 0, 6); idle(20);

    // Clear while running is ignored.
    clr_seen = 0;
    press(0, 1, 0, 6); idle(10);
    chk("clear_in_running", 32'(state), 32'd1);
    chk("clear_in_running_clr", 32'(clr_seen), 32'd0);

    // Simultaneous start+clear: start wins in RUNNING, clear wins in PAUSED.
    press(1, 1, 0, 6); idle(10);
    chk("both_in_running", 32'(state), 32'd2);
    clr_seen = 0;
    press(1, 1, 0, 6); idle(10);
    chk("both_in_paused", 32'(state), 32'd0);
    chk("clr_pulse_count", 32'(clr_seen), 32'd1);

    // Bounce shorter than the debounce window.
    press(1, 0, 0, 3); idle(1); press(1, 0, 0, 3); idle(10);
    chk("glitch_ignored", 32'(state), 32'd0);
    press(1, 0, 0, 6); idle(10);
    chk("after_glitch_run", 32'(state), 32'd1);

`ifdef STOPWATCH_LAP_EN
    press(0, 0, 1, 6); idle(25);
    chk("lap_hold", 32'(hold), 32'd1);
    press(0, 0, 1, 6); idle(10);
    chk("lap_release", 32'(hold), 32'd0);
    press(0, 0, 1, 6); idle(7);
`endif

    // Asynchronous reset mid-count clears outputs before the next edge.
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_run",   32'(run),   32'd0);
    chk("async_rst_tick",  32'(tick),  32'd0);
    chk("async_rst_clr",   32'(clr),   32'd0);
    chk("async_rst_hold",  32'(hold),  32'd0);
    @(negedge clk);
    idle(2);
    reset_n = 1'b1;

    // Randomized button activity with bounces of assorted lengths.
    for (int seg = 0; seg < 250; seg++) begin
      press(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 9) < 3), int'($urandom_range(1, 9)));
      idle(int'($urandom_range(0, 30)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/pause/clear sequencer for the Basys3 digital stopwatch. It synchronizes and debounces the raw start/stop, clear and lap buttons, and runs a three- or four-state control FSM. It produces the 0.1 s count-enable tick, the synchronous clear pulse for the BCD digit counter, and a display-hold flag for lap freeze. It sits between the board buttons and the digit counter / seven-segment display path.

## Interface
- `TICK_DIV`, 10_000_000: clk cycles per count tick (0.1 s at 100 MHz); must be ≥ 2.
- `DB_CYCLES`, 1_000_000: consecutive stable samples required to accept a button level change (10 ms); must be ≥ 2.
- `clk` input 1: 100 MHz system clock; all logic is on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `btn_start_stop` input 1: raw start/stop button, active high, asynchronous.
- `btn_clear` input 1: raw clear button, active high, asynchronous.
- `btn_lap` input 1: raw lap button, active high, asynchronous; ignored unless the lap feature is compiled in.
- `run` output 1: high in RUNNING and LAP.
- `tick` output 1: one-cycle enable for the digit counter.
- `clr` output 1: one-cycle synchronous clear for the digit counter.
- `hold` output 1: display latch freeze, high in LAP only.
- `state` output 2: FSM state for debug LEDs. IDLE=0, RUNNING=1, PAUSED=2, LAP=3.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
  - Debounce counter clears whenever the synced input equals the debounced level, and increments while they differ.
  - The debounced level flips on the DB_CYCLES-th consecutive differing sample.
- A press pulse is one cycle, generated on the debounced 0→1 transition only. Release generates nothing. A held button yields exactly one press.
- FSM transitions, on press pulses:
  - IDLE: start → RUNNING. Clear → IDLE with `clr` pulse.
  - RUNNING: start → PAUSED. Lap → LAP. Clear is ignored.
  - PAUSED: start → RUNNING. Clear → IDLE with `clr` pulse.
  - LAP: lap → RUNNING. Start → PAUSED. Clear is ignored.
- Simultaneous presses in one cycle use priority clear > start > lap. Only the highest-priority press valid in the current state acts; the others are dropped.
- Prescaler: `$clog2(TICK_DIV)` bits.
  - Increments while `run`.
  - At TICK_DIV-1 it asserts `tick` for one cycle and wraps to 0.
  - Holds its value in PAUSED, so a partial interval is preserved.
  - Cleared to 0 when `clr` asserts.
- `tick` is never high when `run` is low. `tick` and `clr` are never high together.
- `hold` does not gate `tick`. The counter keeps counting during LAP; only the display freezes.

## Timing
- Reset values:
  - `state`=IDLE.
  - `run`, `tick`, `clr`, `hold` = 0.
  - Prescaler, debounce counters, synchronizers and debounced levels = 0.
- Reset is asynchronous assert and synchronous deassert at the board level. Reset mid-count returns to IDLE immediately, with no `clr` pulse.
- All outputs are registered.
- From the first clk edge sampling a raw button high, held stable: the press pulse occurs on edge 2+DB_CYCLES, and `state`, `run`, `hold` and `clr` update on the following edge.
- First `tick` after entering RUNNING from IDLE: TICK_DIV cycles after `run` rises. After that, `tick` repeats every TICK_DIV cycles while `run` is high.
- Bounces shorter than DB_CYCLES cycles produce no press.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - LAP state, `btn_lap` debouncer and `hold` output are built as described.
- Undefined:
  - No lap debouncer, and `btn_lap` is unconnected internally.
  - `hold` is tied to 0, and `state` never takes value 3.
  - All other behaviour is identical.

## Test plan
All scenarios use TICK_DIV=10 and DB_CYCLES=4.
- Reset, then a start press held 20 cycles → `run`=1 on edge 7 after press. First `tick` 10 cycles later, then every 10 cycles. Exactly one state change for the held press.
- Start glitch of 3 cycles high, 1 low, 3 high → no transition. Then hold high 4+ cycles → RUNNING.
- RUNNING for 25 cycles (2 ticks, prescaler=5), start press → PAUSED, `tick` silent. Start press → RUNNING, next `tick` exactly 5 cycles after `run` rises.
- PAUSED, clear press → one-cycle `clr`, state IDLE, prescaler 0. Clear while RUNNING → no `clr`, state unchanged.
- Start and clear debounced on the same cycle, in PAUSED → clear wins (IDLE, `clr`=1). In RUNNING → start wins (PAUSED).
- With `STOPWATCH_LAP_EN`: RUNNING, lap press → `hold`=1, `tick` continues. Lap again → `hold`=0. Drop `reset_n` mid-LAP → all outputs 0 the same cycle.
